des_key_schedule: RTL and testbench

- Sequential DES key schedule stage; sits directly upstream of des_pc2.
- Loads a 64-bit key and applies PC-1 to form the 56-bit C||D register.
- Steps C and D through the 16 per-round rotations on request and presents the round's 56-bit CD to des_pc2, which produces the 48-bit subkey.
- Supports encrypt order (K1..K16) and decrypt order (K16..K1).

---
 rtl/des_key_schedule.sv | 140 ++++++++++++++
 tb/tb_des_key_schedule.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_schedule.sv
// ---------------------------------------------------------------------------
// des_key_schedule
//
// Sequential DES key schedule stage. A load strobe captures a 64-bit key,
// applies PC-1 to form the 56-bit C||D register and restarts the schedule.
// Each advance steps C and D (independent 28-bit rotates) to the next round.
// The current round's CD is presented to the downstream des_pc2, which
// forms the 48-bit subkey.
//
// Encrypt order walks K1..K16 by rotating left. Decrypt order walks
// K16..K1 by rotating right. Because the shift table sums to 28, CD16 is
// identical to CD0, so a decrypt load can present PC1(key) directly.
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   key_in   in   [1:64] DES key, bit 1 is MSB, parity bits ignored
//   load     in   captures key_in/decrypt and restarts at round 1
//   decrypt  in   sampled on load only, 1 = reverse round order
//   advance  in   step to the next round (ignored when idle or at round 16)
//   cd_out   out  [1:56] current round C||D (C = bits 1..28)
//   round    out  [4:0] current round 1..16, 0 when idle
//   valid    out  cd_out holds a legal round value
//   last     out  high when round == 16
//
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module des_key_schedule (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:64] key_in,
    input  logic        load,
    input  logic        decrypt,
    input  logic        advance,
    output logic [1:56] cd_out,
    output logic [4:0]  round,
    output logic        valid,
    output logic        last
);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e      state_q, state_d;
    logic [55:0] cd_q, cd_d;
    logic [4:0]  round_q, round_d;
    logic        dir_q, dir_d;
    logic        last_q, last_d;

    logic [55:0] pc1Key;
    logic        unusedParity;

    // PC-1 selection: MSB of pc1Key is C bit 1, LSB is D bit 28.
    assign pc1Key = {
        key_in[57], key_in[49], key_in[41], key_in[33], key_in[25], key_in[17], key_in[9],
        key_in[1],  key_in[58], key_in[50], key_in[42], key_in[34], key_in[26], key_in[18],
        key_in[10], key_in[2],  key_in[59], key_in[51], key_in[43], key_in[35], key_in[27],
        key_in[19], key_in[11], key_in[3],  key_in[60], key_in[52], key_in[44], key_in[36],
        key_in[63], key_in[55], key_in[47], key_in[39], key_in[31], key_in[23], key_in[15],
        key_in[7],  key_in[62], key_in[54], key_in[46], key_in[38], key_in[30], key_in[22],
        key_in[14], key_in[6],  key_in[61], key_in[53], key_in[45], key_in[37], key_in[29],
        key_in[21], key_in[13], key_in[5],  key_in[28], key_in[20], key_in[12], key_in[4]
    };

    // Parity bits take no part in the schedule.
    assign unusedParity = ^{key_in[8],  key_in[16], key_in[24], key_in[32],
                            key_in[40], key_in[48], key_in[56], key_in[64]};

    // Shift amount for round r is 1 in rounds 1, 2, 9, 16 and 2 otherwise.
    function automatic logic shiftIsTwo(input logic [4:0] r);
        return !((r == 5'd1) || (r == 5'd2) || (r == 5'd9) || (r == 5'd16));
    endfunction

    function automatic logic [27:0] rol28(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] ror28(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    // State register; reset clears everything including the direction flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cd_q    <= '0;
            round_q <= '0;
            dir_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cd_q    <= cd_d;
            round_q <= round_d;
            dir_q   <= dir_d;
            last_q  <= last_d;
        end
    end

    // Next-state logic. Load has priority over advance and may restart a
    // schedule at any point. Encrypt load lands on CD1 (one left shift of
    // PC1), decrypt load lands on CD16 which equals PC1 itself. Decrypt
    // stepping from round r undoes the encrypt shift of round 17-r.
    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        round_d = round_q;
        dir_d   = dir_q;
        last_d  = last_q;

        if (load) begin
            state_d = RUN;
            round_d = 5'd1;
            dir_d   = decrypt;
            if (decrypt) begin
                cd_d = pc1Key;
            end else begin
                cd_d = {rol28(pc1Key[55:28], 1'b0), rol28(pc1Key[27:0], 1'b0)};
            end
        end else if (advance && (state_q == RUN) && (round_q != 5'd16)) begin
            round_d = round_q + 5'd1;
            if (dir_q) begin
                cd_d = {ror28(cd_q[55:28], shiftIsTwo(5'd17 - round_q)),
                        ror28(cd_q[27:0],  shiftIsTwo(5'd17 - round_q))};
            end else begin
                cd_d = {rol28(cd_q[55:28], shiftIsTwo(round_q + 5'd1)),
                        rol28(cd_q[27:0],  shiftIsTwo(round_q + 5'd1))};
            end
        end

        last_d = (round_d == 5'd16);
    end

    assign cd_out = cd_q;
    assign round  = round_q;
    assign valid  = (state_q == RUN);
    assign last   = last_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// ---------------------------------------------------------------------------
// tb_des_key_schedule
//
// Directed bench for des_key_schedule. Each step drives inputs on the
// falling edge, advances a behavioural model of the schedule and pushes the
// expected registered outputs onto a scoreboard queue; after the next
// rising edge the entry is popped and compared. Known FIPS-46 example
// values anchor the model, and a PC-2 model turns CD values into subkeys.
// ---------------------------------------------------------------------------
module tb_des_key_schedule;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:64] key_in;
    logic        load;
    logic        decrypt;
    logic        advance;
    logic [1:56] cd_out;
    logic [4:0]  round;
    logic        valid;
    logic        last;

    typedef struct packed {
        logic [55:0] cd;
        logic [4:0]  rnd;
        logic        vld;
        logic        lst;
    } exp_t;

    exp_t sbQ[$];

    int checkCount = 0;
    int passCount  = 0;

    logic [1:56] mCd;
    int          mRound;
    logic        mValid;
    logic        mDir;
    logic [47:0] encK [1:16];

    localparam logic [1:64] KEY_A = 64'h133457799BBCDFF1;
    localparam logic [1:64] KEY_B = 64'h0E329232EA6D0D73;
    localparam logic [1:64] KEY_C = 64'hA5C3F00F12345678;

    localparam int PC1T [56] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
                                 10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
                                 63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
                                 14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};

    localparam int PC2T [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
                                 23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                                 41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    localparam int STAB [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    des_key_schedule dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_in  (key_in),
        .load    (load),
        .decrypt (decrypt),
        .advance (advance),
        .cd_out  (cd_out),
        .round   (round),
        .valid   (valid),
        .last    (last)
    );

    always #5 clk = ~clk;

    function automatic logic [1:56] mPc1(input logic [1:64] k);
        logic [1:56] r;
        for (int i = 1; i <= 56; i++) r[i] = k[PC1T[i-1]];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [1:56] cd);
        logic [1:48] r;
        for (int i = 1; i <= 48; i++) r[i] = cd[PC2T[i-1]];
        return r;
    endfunction

    // Rotates both halves one position at a time, n times.
    function automatic logic [1:56] mRot(input logic [1:56] cd, input int n, input bit left);
        logic [1:56] tmp;
        for (int k = 0; k < n; k++) begin
            tmp = cd;
            for (int i = 0; i < 28; i++) begin
                if (left) begin
                    cd[1 + i]  = tmp[1 + ((i + 1) % 28)];
                    cd[29 + i] = tmp[29 + ((i + 1) % 28)];
                end else begin
                    cd[1 + i]  = tmp[1 + ((i + 27) % 28)];
                    cd[29 + i] = tmp[29 + ((i + 27) % 28)];
                end
            end
        end
        return cd;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic modelReset();
        mCd    = '0;
        mRound = 0;
        mValid = 1'b0;
        mDir   = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        if (sbQ.size() == 0) begin
            check({tag, "_sbEmpty"}, 64'd0, 64'd1);
        end else begin
            e = sbQ.pop_front();
            check({tag, "_cd"},    cd_out, e.cd);
            check({tag, "_round"}, round,  e.rnd);
            check({tag, "_valid"}, valid,  e.vld);
            check({tag, "_last"},  last,   e.lst);
        end
    endtask

    // Drive one cycle of inputs, predict the registered result, compare it.
    task automatic applyStimulus(input logic ld, input logic adv, input logic [1:64] k,
                                 input logic dec, input string tag);
        exp_t e;
        @(negedge clk);
        load    = ld;
        advance = adv;
        key_in  = k;
        decrypt = dec;
        if (ld) begin
            mDir   = dec;
            mRound = 1;
            mValid = 1'b1;
            mCd    = dec ? mPc1(k) : mRot(mPc1(k), STAB[1], 1'b1);
        end else if (adv && mValid && (mRound < 16)) begin
            mRound++;
            mCd = mDir ? mRot(mCd, STAB[18 - mRound], 1'b0) : mRot(mCd, STAB[mRound], 1'b1);
        end
        e.cd  = mCd;
        e.rnd = mRound[4:0];
        e.vld = mValid;
        e.lst = (mRound == 16);
        sbQ.push_back(e);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        rst_n   = 1'b0;
        load    = 1'b0;
        advance = 1'b0;
        decrypt = 1'b0;
        key_in  = '0;
        modelReset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_cd",    cd_out, 56'h0);
        check("rst_round", round,  5'd0);
        check("rst_valid", valid,  1'b0);
        check("rst_last",  last,   1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Advance while idle is ignored
        applyStimulus(1'b0, 1'b1, KEY_A, 1'b0, "idleAdv");
        applyStimulus(1'b0, 1'b1, KEY_A, 1'b0, "idleAdv");

        // Encrypt order, back to back
        applyStimulus(1'b1, 1'b0, KEY_A, 1'b0, "encLoad");
        encK[1] = pc2(mCd);
        check("encCD1", cd_out, 56'hE19955FAACCF1E);
        check("encK1",  pc2(cd_out), 48'h1B02EFFC7072);
        for (int r = 2; r <= 16; r++) begin
            applyStimulus(1'b0, 1'b1, KEY_A, 1'b0, "encAdv");
            encK[r] = pc2(mCd);
        end
        check("encCD16", cd_out, 56'hF0CCAAF556678F);
        check("encK16",  pc2(cd_out), 48'hCB3D8B0E17F5);
        check("encLast", last, 1'b1);

        // Saturation at round 16
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, KEY_A, 1'b0, "satAdv");
            applyStimulus(1'b0, 1'b0, KEY_A, 1'b0, "satGap");
        end
        check("satCD", cd_out, 56'hF0CCAAF556678F);

        // Decrypt order gives the encrypt subkeys reversed
        applyStimulus(1'b1, 1'b0, KEY_A, 1'b1, "decLoad");
        check("decCD16", cd_out, 56'hF0CCAAF556678F);
        check("decK16",  pc2(cd_out), 48'hCB3D8B0E17F5);
        for (int r = 2; r <= 16; r++) begin
            applyStimulus(1'b0, 1'b1, KEY_A, 1'b1, "decAdv");
            check("decKrev", pc2(cd_out), encK[17 - r]);
        end
        check("decK1", pc2(cd_out), 48'h1B02EFFC7072);

        // Key/decrypt changes without load have no effect
        applyStimulus(1'b0, 1'b0, KEY_B, 1'b0, "noLoad");
        applyStimulus(1'b0, 1'b0, KEY_C, 1'b1, "noLoad");

        // Restart mid-schedule: load wins over advance
        applyStimulus(1'b1, 1'b0, KEY_B, 1'b0, "bLoad");
        for (int r = 2; r <= 7; r++) applyStimulus(1'b0, 1'b1, KEY_B, 1'b0, "bAdv");
        check("bRound7", round, 5'd7);
        applyStimulus(1'b1, 1'b1, KEY_C, 1'b0, "loadWins");
        check("restartRound", round, 5'd1);

        // Gapped advance reaches the same K16
        applyStimulus(1'b1, 1'b0, KEY_A, 1'b0, "gapLoad");
        for (int r = 2; r <= 16; r++) begin
            if (r % 4 == 2) begin
                for (int g = 0; g < 5; g++) applyStimulus(1'b0, 1'b0, KEY_B, 1'b1, "gapHold");
            end
            applyStimulus(1'b0, 1'b1, KEY_A, 1'b0, "gapAdv");
        end
        check("gapK16", pc2(cd_out), encK[16]);

        // Asynchronous reset in the middle of a run
        applyStimulus(1'b1, 1'b0, KEY_A, 1'b0, "rstLoad");
        for (int r = 0; r < 4; r++) applyStimulus(1'b0, 1'b1, KEY_A, 1'b0, "rstAdv");
        #2;
        rst_n = 1'b0;
        #1;
        check("asyncRst_cd",    cd_out, 56'h0);
        check("asyncRst_round", round,  5'd0);
        check("asyncRst_valid", valid,  1'b0);
        check("asyncRst_last",  last,   1'b0);
        modelReset();
        applyStimulus(1'b0, 1'b1, KEY_A, 1'b0, "inReset");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b1, KEY_A, 1'b0, "postRstAdv");
        applyStimulus(1'b0, 1'b1, KEY_A, 1'b0, "postRstAdv");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
